// File: rtl/riscv_mdu_sequencer_if.sv
// Handshake bundle between the EX/MEM pipeline control and the multi-cycle M-extension sequencer.
// The master side is the pipeline; the slave side is riscv_mdu_sequencer.
interface riscv_mdu_sequencer_if;
  logic       ivalid_ex;
  logic       iop_div_ex;
  logic [4:0] ird_ex;
  logic       iflush_ex;
  logic       istall_mem;
  logic       ostart;
  logic [5:0] ocount;
  logic       odone;
  logic       obusy;
  logic [4:0] ord_busy;
  logic       ostall_ex;
  logic       oabort;
  logic       oillegal;

  modport master (
    output ivalid_ex, iop_div_ex, ird_ex, iflush_ex, istall_mem,
    input  ostart, ocount, odone, obusy, ord_busy, ostall_ex, oabort, oillegal
  );

  modport slave (
    input  ivalid_ex, iop_div_ex, ird_ex, iflush_ex, istall_mem,
    output ostart, ocount, odone, obusy, ord_busy, ostall_ex, oabort, oillegal
  );
endinterface

// File: rtl/riscv_mdu_sequencer.sv
// IDLE/RUN/DONE sequencer for an iterative multiply/divide datapath in EX.
// Define RISCV_MDU_DIV_EN to support div/rem; without it divides are flagged on oillegal.
module riscv_mdu_sequencer #(
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 32
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  riscv_mdu_sequencer_if.slave  mdu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  if (LAT_MUL < 1 || LAT_MUL > 63 || LAT_DIV < 1 || LAT_DIV > 63) begin : g_bad_lat
    $error("riscv_mdu_sequencer: LAT_MUL and LAT_DIV must be in 1..63");
  end

  localparam logic [5:0] LAT_MUL_W = 6'(LAT_MUL);

  state_e     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [5:0] lat_q, lat_d;
  logic [4:0] rd_q, rd_d;
  logic       start_q, start_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       div_ok;
  logic       accept;
  logic       idle;

`ifdef RISCV_MDU_DIV_EN
  localparam logic [5:0] LAT_DIV_W = 6'(LAT_DIV);
  assign div_ok       = 1'b1;
  assign mdu.oillegal = 1'b0;
`else
  assign div_ok       = ~mdu.iop_div_ex;
  assign mdu.oillegal = idle & mdu.ivalid_ex & mdu.iop_div_ex;
`endif

  // Gating with irst_n keeps the combinational outputs quiet while reset is held.
  assign idle   = irst_n & (state_q == IDLE);
  assign accept = idle & mdu.ivalid_ex & ~mdu.iflush_ex & div_ok;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lat_d   = lat_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          count_d = 6'd0;
          rd_d    = mdu.ird_ex;
`ifdef RISCV_MDU_DIV_EN
          lat_d   = mdu.iop_div_ex ? LAT_DIV_W : LAT_MUL_W;
`else
          lat_d   = LAT_MUL_W;
`endif
        end
      end
      RUN: begin
        if (mdu.iflush_ex) begin
          state_d = IDLE;
          count_d = 6'd0;
          rd_d    = 5'd0;
        end else if (count_q == lat_q - 6'd1) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 6'd1;
        end
      end
      DONE: begin
        // A flush seen here belongs to a younger instruction, so only MEM backpressure matters.
        if (!mdu.istall_mem) begin
          state_d = IDLE;
          count_d = 6'd0;
          rd_d    = 5'd0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 6'd0;
        rd_d    = 5'd0;
      end
    endcase
    start_d = (state_q != RUN) && (state_d == RUN);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= IDLE;
      count_q <= 6'd0;
      lat_q   <= 6'd0;
      rd_q    <= 5'd0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lat_q   <= lat_d;
      rd_q    <= rd_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign mdu.ostart    = start_q;
  assign mdu.ocount    = count_q;
  assign mdu.odone     = done_q;
  assign mdu.obusy     = busy_q;
  assign mdu.ord_busy  = rd_q;
  assign mdu.ostall_ex = accept | (state_q == RUN) | ((state_q == DONE) & mdu.istall_mem);
  assign mdu.oabort    = (state_q == RUN) & mdu.iflush_ex;

endmodule
